// File: rtl/monitor_readout_pkg.sv
// Shared types and constants for the monitor readout block.
// MONITOR_READOUT_TIMESTAMP_EN selects two extra timestamp beats per snapshot.
package monitor_readout_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 9;
    localparam int DEF_DEPTH  = 4;

`ifdef MONITOR_READOUT_TIMESTAMP_EN
    localparam int TS_BEATS = 2;
`else
    localparam int TS_BEATS = 0;
`endif

    // Room for the timestamp beat indices in both builds so the port width never changes.
    function automatic int calc_chw(input int num_ch);
        return $clog2(num_ch + 2);
    endfunction

endpackage

// File: rtl/monitor_readout_if.sv
// Valid/ready beat stream carrying one monitor channel (or timestamp half) per beat.
interface monitor_readout_if #(
    parameter int WIDTH = 8,
    parameter int CHW   = 4
);
    logic [WIDTH-1:0] out_data;
    logic [CHW-1:0]   out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (output out_data, output out_ch, output out_valid, output out_last,
                    input  out_ready);
    modport slave  (input  out_data, input  out_ch, input  out_valid, input  out_last,
                    output out_ready);
endinterface

// File: rtl/monitor_readout_snap_fifo.sv
// Snapshot FIFO: one entry per captured snapshot, count-based full/empty.
// o_next exposes the entry after the head (or the incoming one) for gapless streaming.
module mon_snap_fifo #(
    parameter  int ENTRY_W = 72,
    parameter  int DEPTH   = 4,
    localparam int PTRW    = $clog2(DEPTH),
    localparam int CNTW    = PTRW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_din,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head,
    output logic [ENTRY_W-1:0] o_next,
    output logic               o_full,
    output logic               o_empty,
    output logic [CNTW-1:0]    o_count
);
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]    r_wr_ptr;
    logic [PTRW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]    r_count;
    logic [PTRW-1:0]    w_rd_ptr_inc;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_rd_ptr_inc = r_rd_ptr + PTRW'(1);
    assign o_head  = r_mem[r_rd_ptr];
    // With a single entry left, the only follower is the one being pushed this cycle.
    assign o_next  = (r_count > CNTW'(1)) ? r_mem[w_rd_ptr_inc] : i_din;
    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/monitor_readout.sv
// Captures monitor snapshots on trig and streams them one channel per beat.
// MONITOR_READOUT_TIMESTAMP_EN appends a 2*WIDTH cycle-count timestamp as two beats.
module monitor_readout
    import monitor_readout_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CHW    = calc_chw(NUM_CH),
    localparam int CNTW   = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] mon_bus,
    input  logic                    trig,
    monitor_readout_if.master       out_if,
    output logic [CNTW-1:0]         snap_count,
    output logic                    overflow
);
    localparam int             BEATS    = NUM_CH + TS_BEATS;
    localparam int             ENTRY_W  = BEATS * WIDTH;
    localparam logic [CHW-1:0] LAST_IDX = CHW'(BEATS - 1);

    state_t             r_state, w_state_nxt;
    logic [CHW-1:0]     r_idx, w_idx_nxt;
    logic [WIDTH-1:0]   r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_last, w_last_nxt;
    logic               r_overflow;
    logic               w_accept, w_pop, w_push, w_full, w_empty;
    logic [ENTRY_W-1:0] w_din, w_head, w_next;
    logic [CNTW-1:0]    w_count;

`ifdef MONITOR_READOUT_TIMESTAMP_EN
    logic [2*WIDTH-1:0] r_ts_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_ts_cnt <= '0;
        else       r_ts_cnt <= r_ts_cnt + (2*WIDTH)'(1);
    end

    assign w_din = {r_ts_cnt, mon_bus};
`else
    assign w_din = mon_bus;
`endif

    function automatic logic [WIDTH-1:0] beat_of(input logic [ENTRY_W-1:0] e,
                                                 input logic [CHW-1:0]     b);
        return e[int'(b)*WIDTH +: WIDTH];
    endfunction

    assign w_accept = r_valid && out_if.out_ready;
    assign w_pop    = w_accept && r_last;
    // A final-beat pop frees a slot in the same edge, so a full FIFO can still take trig.
    assign w_push   = trig && (!w_full || w_pop);

    mon_snap_fifo #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                    w_data_nxt  = beat_of(w_head, '0);
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (LAST_IDX == '0);
                end
            end
            SEND: begin
                if (w_accept) begin
                    if (r_last) begin
                        if ((w_count > CNTW'(1)) || w_push) begin
                            w_idx_nxt  = '0;
                            w_data_nxt = beat_of(w_next, '0);
                            w_last_nxt = (LAST_IDX == '0);
                        end else begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = '0;
                            w_data_nxt  = '0;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_idx_nxt  = r_idx + CHW'(1);
                        w_data_nxt = beat_of(w_head, r_idx + CHW'(1));
                        w_last_nxt = ((r_idx + CHW'(1)) == LAST_IDX);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_overflow <= r_overflow | (trig && !w_push);
        end
    end

    assign out_if.out_data  = r_data;
    assign out_if.out_ch    = r_idx;
    assign out_if.out_valid = r_valid;
    assign out_if.out_last  = r_last;
    assign snap_count       = w_count;
    assign overflow         = r_overflow;

endmodule
